zbt_arbiter: RTL and testbench
==============================

// Module: zbt_arbiter
// PURPOSE
//  Round-robin arbiter sharing one ZBT_Interface between NREQ requesters (audio record, playback, packet buffer).
//  Accepts one read/write request per cycle, drives the ZBT op/addr/din/bwe bus registered, and tracks in-flight reads.
//  Read tags are held in a FIFO so each zbt_nd/zbt_dout return is routed back to the requester that issued the read.
//  Sits between the requester blocks and ZBT_Interface; the top level ties ZBT_Interface reset = ~reset_b.
// PARAMETERS
//  NREQ       3   number of requesters (2..8)
//  AW         19  address width
//  DW         36  data width
//  TAG_DEPTH  4   max in-flight reads (power of 2)
// PORTS
//  clk_27mhz  in   1        system clock, all logic on posedge
//  reset_b    in   1        synchronous active-low reset
//  req        in   NREQ     request i pending; held with its fields until gnt[i]
//  req_we     in   NREQ     1 = write, 0 = read, per requester
//  req_addr   in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//  req_din    in   NREQ*DW  packed write data
//  req_bwe    in   NREQ*4   packed byte-write enables (passed through unchanged)
//  gnt        out  NREQ     combinational one-hot: request i accepted at this edge
//  rd_data    out  DW       read data, shared by all requesters
//  rd_valid   out  NREQ     one-hot 1-cycle pulse: rd_data belongs to requester i
//  err        out  1        sticky: zbt_nd arrived with tag FIFO empty
//  zbt_ready  in   1        ZBT_Interface can accept an op
//  zbt_op     out  2        00 IDLE, 01 READ, 10 WRITE (never 11)
//  zbt_addr   out  AW       registered address
//  zbt_din    out  DW       registered write data
//  zbt_bwe    out  4        registered byte enables
//  zbt_nd     in   1        ZBT read data valid
//  zbt_dout   in   DW       ZBT read data
// BEHAVIOUR
//  Reset (reset_b=0 at edge): zbt_op=00, zbt_addr/din/bwe=0, rd_data=0, rd_valid=0, err=0.
//   Tag FIFO emptied; rr pointer=NREQ-1, so requester 0 has highest priority first.
//   Reset mid-transfer drops pending tags. ZBT is reset together, so no stale nd is expected.
//  Eligibility: elig[i] = req[i] & (req_we[i] | ~tag_full); tag_full = registered count==TAG_DEPTH.
//  gnt: if zbt_ready & |elig, gnt = first elig index after rr pointer (wrapping); otherwise 0.
//   gnt is 0 whenever reset_b=0.
//  Accept edge (gnt[i]=1):
//   zbt_op <= req_we[i] ? 10 : 01; zbt_addr/din/bwe <= requester i fields; rr <= i.
//   Read: push tag i. Requester may change/drop req on the same edge.
//  No grant: zbt_op <= 00, addr/din/bwe hold previous values.
//  Latency: ZBT op appears 1 cycle after the gnt cycle. Max 1 op per cycle; back-to-back grants allowed.
//  Return: edge with zbt_nd=1 and FIFO non-empty -> pop tag t.
//   Next cycle: rd_valid[t]=1, rd_data=zbt_dout (registered). rd_data holds between pulses.
//  zbt_nd with FIFO empty: no rd_valid, err<=1 (sticky until reset).
//  Simultaneous push and pop: both happen, count unchanged. Full blocks reads even if a pop occurs that edge.
//  Writes never blocked by tag_full. Returns are FIFO-ordered; ZBT_Interface returns reads in issue order.
//  req_we is ignored when req=0.
// TESTING
//  1 Reset: hold reset_b=0 3 cycles with req=3'b111 -> gnt=0, zbt_op=00, err=0, rd_valid=0.
//  2 Round-robin: req=111 continuously, zbt_ready=1 -> gnt sequence 001,010,100,001.
//    zbt_op follows each grant 1 cycle later.
//  3 Read return: req0 read addr 0x00004 -> zbt_op=01/addr=4 next cycle.
//    Model nd 2 cycles later with dout=36'hACAFEBABE -> rd_valid=001, rd_data=ACAFEBABE.
//  4 Tag ordering: reads from req2 then req1 back-to-back, returns A then B -> rd_valid 100 (A) then 010 (B).
//  5 Backpressure: hold zbt_nd=0, issue 5 reads -> 4 grants, then req0 read stalls.
//    Same-cycle req1 write (addr 6, bwe 0101, din ACAFEBABE) is still granted.
//    zbt_ready=0 -> gnt=0, zbt_op=00.
//  6 Error: zbt_nd=1 with no outstanding read -> err=1, rd_valid=0. err stays high until reset_b=0.

Source files
------------

// File: rtl/zbt_arbiter_if.sv
// ---------------------------------------------------------------------------
// zbt_arbiter_if
// Bundles the requester handshake and the ZBT op/return bus that the
// round-robin arbiter sits between.
//   Requester side : req, req_we, req_addr, req_din, req_bwe (into the arbiter)
//                    gnt, rd_data, rd_valid, err              (out of the arbiter)
//   ZBT side       : zbt_ready, zbt_nd, zbt_dout              (into the arbiter)
//                    zbt_op, zbt_addr, zbt_din, zbt_bwe       (out of the arbiter)
// Modports:
//   slave  - the arbiter's view
//   master - the surrounding requesters / ZBT_Interface view
// ---------------------------------------------------------------------------
interface zbt_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 19,
    parameter int DW   = 36
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_din;
    logic [NREQ*4-1:0]  req_bwe;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      rd_data;
    logic [NREQ-1:0]    rd_valid;
    logic               err;
    logic               zbt_ready;
    logic [1:0]         zbt_op;
    logic [AW-1:0]      zbt_addr;
    logic [DW-1:0]      zbt_din;
    logic [3:0]         zbt_bwe;
    logic               zbt_nd;
    logic [DW-1:0]      zbt_dout;

    modport slave (
        input  req, req_we, req_addr, req_din, req_bwe,
        input  zbt_ready, zbt_nd, zbt_dout,
        output gnt, rd_data, rd_valid, err,
        output zbt_op, zbt_addr, zbt_din, zbt_bwe
    );

    modport master (
        output req, req_we, req_addr, req_din, req_bwe,
        output zbt_ready, zbt_nd, zbt_dout,
        input  gnt, rd_data, rd_valid, err,
        input  zbt_op, zbt_addr, zbt_din, zbt_bwe
    );
endinterface

// File: rtl/zbt_arbiter.sv
// ---------------------------------------------------------------------------
// zbt_arbiter
// Round-robin arbiter sharing one ZBT_Interface between NREQ requesters.
// One read or write is accepted per cycle and presented on the ZBT bus one
// cycle later through registers. The requester index of every accepted read
// is pushed into a small tag FIFO so each zbt_nd return is steered back to
// the requester that issued it (ZBT returns reads in issue order).
// Ports:
//   clk_27mhz - system clock, all state on the rising edge
//   reset_b   - synchronous active-low reset
//   bus       - zbt_arbiter_if.slave: requester handshake + ZBT op/return bus
//               gnt is combinational; every other output is registered.
// ---------------------------------------------------------------------------
module zbt_arbiter #(
    parameter int NREQ      = 3,
    parameter int AW        = 19,
    parameter int DW        = 36,
    parameter int TAG_DEPTH = 4
) (
    input  logic          clk_27mhz,
    input  logic          reset_b,
    zbt_arbiter_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH + 1);

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    // Expand a requester index into a one-hot requester vector.
    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] vec;
        vec = '0;
        for (int k = 0; k < NREQ; k++) begin
            vec[k] = (idx == IW'(k)) ? 1'b1 : 1'b0;
        end
        return vec;
    endfunction

    // Arbitration state
    logic [IW-1:0]   rr_r;
    logic [NREQ-1:0] elig_s;
    logic [NREQ-1:0] gnt_s;
    logic [IW-1:0]   gnt_idx_s;
    logic            gnt_any_s;
    logic [IW-1:0]   cand_s;

    // Fields of the granted requester
    logic            sel_we_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_din_s;
    logic [3:0]      sel_bwe_s;

    // Registered ZBT bus
    logic [1:0]      zbt_op_r;
    logic [AW-1:0]   zbt_addr_r;
    logic [DW-1:0]   zbt_din_r;
    logic [3:0]      zbt_bwe_r;

    // Read tag FIFO
    logic [IW-1:0]   tag_mem_r [TAG_DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            tag_full_s;
    logic            tag_empty_s;
    logic            push_s;
    logic            pop_s;

    // Return path
    logic [DW-1:0]   rd_data_r;
    logic [NREQ-1:0] rd_valid_r;
    logic            err_r;

    // Full is judged on the registered count, so a pop on the same edge
    // does not reopen the door for a read.
    assign tag_full_s  = (count_r == CW'(TAG_DEPTH));
    assign tag_empty_s = (count_r == {CW{1'b0}});
    assign elig_s      = bus.req & (bus.req_we | {NREQ{~tag_full_s}});

    // Pick the first eligible requester after the last winner, wrapping.
    always_comb begin
        gnt_s     = '0;
        gnt_idx_s = '0;
        gnt_any_s = 1'b0;
        cand_s    = '0;
        if (reset_b && bus.zbt_ready) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand_s = IW'((int'(rr_r) + k) % NREQ);
                if (!gnt_any_s && elig_s[cand_s]) begin
                    gnt_any_s = 1'b1;
                    gnt_idx_s = cand_s;
                end else begin
                    gnt_any_s = gnt_any_s;
                end
            end
            if (gnt_any_s) begin
                gnt_s = idx_to_onehot(gnt_idx_s);
            end else begin
                gnt_s = '0;
            end
        end else begin
            gnt_s = '0;
        end
    end

    // AND-OR mux of the granted requester's fields (gnt_s is one-hot or zero).
    always_comb begin
        sel_we_s   = 1'b0;
        sel_addr_s = '0;
        sel_din_s  = '0;
        sel_bwe_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sel_we_s   = sel_we_s   | (gnt_s[k] & bus.req_we[k]);
            sel_addr_s = sel_addr_s | (gnt_s[k] ? bus.req_addr[k*AW +: AW] : {AW{1'b0}});
            sel_din_s  = sel_din_s  | (gnt_s[k] ? bus.req_din[k*DW +: DW]  : {DW{1'b0}});
            sel_bwe_s  = sel_bwe_s  | (gnt_s[k] ? bus.req_bwe[k*4 +: 4]    : 4'b0000);
        end
    end

    assign push_s = gnt_any_s & ~sel_we_s;
    assign pop_s  = bus.zbt_nd & ~tag_empty_s;

    // ZBT op/addr/din/bwe registers and round-robin pointer.
    always_ff @(posedge clk_27mhz) begin
        if (!reset_b) begin
            zbt_op_r   <= OP_IDLE;
            zbt_addr_r <= '0;
            zbt_din_r  <= '0;
            zbt_bwe_r  <= 4'b0000;
            rr_r       <= IW'(NREQ - 1);
        end else if (gnt_any_s) begin
            zbt_op_r   <= sel_we_s ? OP_WRITE : OP_READ;
            zbt_addr_r <= sel_addr_s;
            zbt_din_r  <= sel_din_s;
            zbt_bwe_r  <= sel_bwe_s;
            rr_r       <= gnt_idx_s;
        end else begin
            // Address/data/enables hold; only the op drops to idle.
            zbt_op_r   <= OP_IDLE;
        end
    end

    // Tag storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk_27mhz) begin
        if (reset_b && push_s) begin
            tag_mem_r[wr_ptr_r] <= gnt_idx_s;
        end
    end

    // Tag FIFO pointers and occupancy; push and pop on one edge cancel.
    always_ff @(posedge clk_27mhz) begin
        if (!reset_b) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Route returned data to the oldest outstanding tag; flag orphan returns.
    always_ff @(posedge clk_27mhz) begin
        if (!reset_b) begin
            rd_data_r  <= '0;
            rd_valid_r <= '0;
            err_r      <= 1'b0;
        end else begin
            if (pop_s) begin
                rd_valid_r <= idx_to_onehot(tag_mem_r[rd_ptr_r]);
                rd_data_r  <= bus.zbt_dout;
            end else begin
                rd_valid_r <= '0;
            end
            if (bus.zbt_nd && tag_empty_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign bus.gnt      = gnt_s;
    assign bus.zbt_op   = zbt_op_r;
    assign bus.zbt_addr = zbt_addr_r;
    assign bus.zbt_din  = zbt_din_r;
    assign bus.zbt_bwe  = zbt_bwe_r;
    assign bus.rd_data  = rd_data_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.err      = err_r;

endmodule

// File: tb/tb_zbt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_zbt_arbiter
// Directed scenarios with literal expectations, followed by randomized
// traffic. A transaction-level model (last-winner index, queue of read tags,
// expected bus values) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_zbt_arbiter;
    localparam int NREQ      = 3;
    localparam int AW        = 19;
    localparam int DW        = 36;
    localparam int TAG_DEPTH = 4;

    logic clk = 1'b0;
    logic reset_b;
    always #5 clk = ~clk;

    zbt_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    zbt_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk_27mhz (clk),
        .reset_b   (reset_b),
        .bus       (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit check_en = 1'b0;
    logic [NREQ-1:0] last_gnt = '0;

    // Reference model state: what the registered outputs must hold now.
    int            m_rr   = NREQ - 1;
    logic [1:0]    m_op   = 2'b00;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din  = '0;
    logic [3:0]    m_bwe  = '0;
    logic [DW-1:0] m_rd   = '0;
    logic [NREQ-1:0] m_rv = '0;
    logic          m_err  = 1'b0;
    int            m_tags [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input int i);
        bus.req[i]              = ($urandom_range(0, 99) < 60);
        bus.req_we[i]           = 1'($urandom_range(0, 1));
        bus.req_addr[i*AW +: AW] = AW'($urandom);
        bus.req_din[i*DW +: DW]  = {4'($urandom), 32'($urandom)};
        bus.req_bwe[i*4 +: 4]    = 4'($urandom);
    endtask

    // Compare process: predict gnt, compare all outputs, then advance the model.
    always @(negedge clk) begin
        automatic int sel = -1;
        automatic logic [NREQ-1:0] eg = '0;
        if (reset_b === 1'b1 && bus.zbt_ready === 1'b1) begin
            for (int k = 1; k <= NREQ; k++) begin
                automatic int i;
                i = (m_rr + k) % NREQ;
                if (sel < 0 && bus.req[i] && (bus.req_we[i] || m_tags.size() < TAG_DEPTH))
                    sel = i;
            end
        end
        if (sel >= 0) eg[sel] = 1'b1;
        last_gnt = bus.gnt;
        if (check_en) begin
            chk("gnt", bus.gnt, eg);
            chk("zbt_op", bus.zbt_op, m_op);
            chk("zbt_addr", bus.zbt_addr, m_addr);
            chk("zbt_din", bus.zbt_din, m_din);
            chk("zbt_bwe", bus.zbt_bwe, m_bwe);
            chk("rd_valid", bus.rd_valid, m_rv);
            chk("rd_data", bus.rd_data, m_rd);
            chk("err", bus.err, m_err);
        end
        if (reset_b !== 1'b1) begin
            m_rr = NREQ - 1; m_op = 2'b00; m_addr = '0; m_din = '0; m_bwe = '0;
            m_rd = '0; m_rv = '0; m_err = 1'b0; m_tags.delete();
        end else begin
            m_rv = '0;
            if (bus.zbt_nd) begin
                if (m_tags.size() > 0) begin
                    m_rv[m_tags.pop_front()] = 1'b1;
                    m_rd = bus.zbt_dout;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (sel >= 0) begin
                m_op   = bus.req_we[sel] ? 2'b10 : 2'b01;
                m_addr = bus.req_addr[sel*AW +: AW];
                m_din  = bus.req_din[sel*DW +: DW];
                m_bwe  = bus.req_bwe[sel*4 +: 4];
                m_rr   = sel;
                if (!bus.req_we[sel]) m_tags.push_back(sel);
            end else begin
                m_op = 2'b00;
            end
        end
    end

    logic [NREQ-1:0] rr_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    int grants;

    initial begin
        reset_b       = 1'b0;
        bus.req       = 3'b111;
        bus.req_we    = 3'b000;
        bus.req_addr  = '0;
        bus.req_din   = '0;
        bus.req_bwe   = '0;
        bus.zbt_ready = 1'b1;
        bus.zbt_nd    = 1'b0;
        bus.zbt_dout  = '0;

        // Reset held three cycles with all requests up.
        for (int c = 0; c < 3; c++) begin
            tick();
            check_en = 1'b1;
            #1;
            chk("rst_gnt", bus.gnt, 3'b000);
            chk("rst_op", bus.zbt_op, 2'b00);
            chk("rst_err", bus.err, 1'b0);
            chk("rst_rd_valid", bus.rd_valid, 3'b000);
        end

        // Round-robin over three writers.
        tick();
        reset_b = 1'b1;
        bus.req = 3'b111; bus.req_we = 3'b111;
        bus.req_addr = {19'd3, 19'd2, 19'd1};
        for (int j = 0; j < 4; j++) begin
            if (j > 0) tick();
            #1;
            chk("rr_gnt", bus.gnt, rr_seq[j]);
            if (j > 0) chk("rr_op", bus.zbt_op, 2'b10);
        end
        tick();
        bus.req = 3'b000;
        #1;
        chk("rr_last_addr", bus.zbt_addr, 19'd1);

        // Single read and its return.
        tick();
        bus.req = 3'b001; bus.req_we = 3'b000;
        bus.req_addr[0 +: AW] = 19'h00004;
        #1;
        chk("rd_gnt", bus.gnt, 3'b001);
        tick();
        bus.req = 3'b000;
        #1;
        chk("rd_op", bus.zbt_op, 2'b01);
        chk("rd_addr", bus.zbt_addr, 19'h00004);
        tick();
        tick();
        bus.zbt_nd = 1'b1; bus.zbt_dout = 36'hACAFEBABE;
        tick();
        bus.zbt_nd = 1'b0;
        #1;
        chk("ret_valid", bus.rd_valid, 3'b001);
        chk("ret_data", bus.rd_data, 36'hACAFEBABE);
        tick();
        #1;
        chk("ret_pulse", bus.rd_valid, 3'b000);
        chk("ret_hold", bus.rd_data, 36'hACAFEBABE);

        // Tag ordering: req2 then req1.
        tick();
        bus.req = 3'b100; bus.req_addr[2*AW +: AW] = 19'h00010;
        #1;
        chk("ord_gnt2", bus.gnt, 3'b100);
        tick();
        bus.req = 3'b010; bus.req_addr[1*AW +: AW] = 19'h00020;
        #1;
        chk("ord_gnt1", bus.gnt, 3'b010);
        tick();
        bus.req = 3'b000;
        tick();
        bus.zbt_nd = 1'b1; bus.zbt_dout = 36'h01111AAAA;
        tick();
        bus.zbt_dout = 36'h02222BBBB;
        #1;
        chk("ord_first", bus.rd_valid, 3'b100);
        chk("ord_first_data", bus.rd_data, 36'h01111AAAA);
        tick();
        bus.zbt_nd = 1'b0;
        #1;
        chk("ord_second", bus.rd_valid, 3'b010);
        chk("ord_second_data", bus.rd_data, 36'h02222BBBB);

        // Backpressure: tag FIFO fills after four reads.
        grants = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            bus.req = 3'b001; bus.req_we = 3'b000;
            bus.req_addr[0 +: AW] = AW'(32'h100 + j);
            #1;
            if (bus.gnt[0]) grants++;
        end
        chk("bp_grants", grants, 4);
        tick();
        bus.req = 3'b011; bus.req_we = 3'b010;
        bus.req_addr[1*AW +: AW] = 19'd6;
        bus.req_bwe[1*4 +: 4] = 4'b0101;
        bus.req_din[1*DW +: DW] = 36'hACAFEBABE;
        #1;
        chk("bp_write_gnt", bus.gnt, 3'b010);
        tick();
        bus.zbt_ready = 1'b0;
        #1;
        chk("bp_wr_op", bus.zbt_op, 2'b10);
        chk("bp_wr_addr", bus.zbt_addr, 19'd6);
        chk("bp_wr_bwe", bus.zbt_bwe, 4'b0101);
        chk("bp_wr_din", bus.zbt_din, 36'hACAFEBABE);
        chk("nrdy_gnt", bus.gnt, 3'b000);
        tick();
        #1;
        chk("nrdy_op", bus.zbt_op, 2'b00);
        bus.zbt_ready = 1'b1;
        bus.req = 3'b000;
        bus.zbt_nd = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (j == 3) bus.zbt_nd = 1'b0;
            #1;
            chk("bp_drain", bus.rd_valid, 3'b001);
        end

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset_b = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            bus.zbt_ready = ($urandom_range(0, 99) < 80);
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i] || last_gnt[i]) new_req(i);
            end
            bus.zbt_nd   = (m_tags.size() > 0) && ($urandom_range(0, 99) < 30);
            bus.zbt_dout = {4'($urandom), 32'($urandom)};
        end

        // Drain outstanding reads, then an orphan return.
        tick();
        reset_b = 1'b1; bus.req = 3'b000; bus.zbt_ready = 1'b1; bus.zbt_nd = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            bus.zbt_nd = (m_tags.size() != 0);
            bus.zbt_dout = {4'($urandom), 32'($urandom)};
        end
        chk("drain_empty", m_tags.size(), 0);
        #1;
        chk("pre_err", bus.err, 1'b0);
        bus.zbt_nd = 1'b1;
        tick();
        bus.zbt_nd = 1'b0;
        #1;
        chk("err_set", bus.err, 1'b1);
        chk("err_no_valid", bus.rd_valid, 3'b000);
        tick();
        tick();
        #1;
        chk("err_sticky", bus.err, 1'b1);
        reset_b = 1'b0;
        tick();
        reset_b = 1'b1;
        #1;
        chk("err_cleared", bus.err, 1'b0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
